// File: rtl/stereo_block_scheduler_if.sv
// stereo_block_scheduler_if
// Bundles the two downstream handshakes of the stereo block scheduler:
//   ub_*  : fill requests to update_buffers and its fill-complete strobe
//   sad_* : presentation of a filled L/R buffer set to the SAD consumer and
//           the consumer's release pulse
// master : scheduler side (drives requests/presentation, receives strobes)
// slave  : downstream side (update_buffers + SAD pair)
interface stereo_block_scheduler_if #(
  parameter int XW = 9,
  parameter int YW = 10,
  parameter int DW = 4
);
  // fill side
  logic          ub_valid_out;
  logic [XW-1:0] ub_left_x_out;
  logic [YW-1:0] ub_left_y_out;
  logic [XW-1:0] ub_right_x_out;
  logic [YW-1:0] ub_right_y_out;
  logic          ub_write_to_front_out;
  logic          ub_valid_in;
  // consumer side
  logic          sad_valid_out;
  logic          sad_front_out;
  logic [XW-1:0] sad_bx_out;
  logic [YW-1:0] sad_by_out;
  logic [DW-1:0] sad_disp_out;
  logic          sad_last_out;
  logic          sad_done_in;

  modport master (
    output ub_valid_out, ub_left_x_out, ub_left_y_out, ub_right_x_out,
           ub_right_y_out, ub_write_to_front_out,
    input  ub_valid_in,
    output sad_valid_out, sad_front_out, sad_bx_out, sad_by_out,
           sad_disp_out, sad_last_out,
    input  sad_done_in
  );

  modport slave (
    input  ub_valid_out, ub_left_x_out, ub_left_y_out, ub_right_x_out,
           ub_right_y_out, ub_write_to_front_out,
    output ub_valid_in,
    input  sad_valid_out, sad_front_out, sad_bx_out, sad_by_out,
           sad_disp_out, sad_last_out,
    output sad_done_in
  );
endinterface

// File: rtl/stereo_block_scheduler.sv
// stereo_block_scheduler
// Walks every (row, left block, disparity) candidate of a stereo frame and
// requests update_buffers fills into two ping-ponged L/R buffer sets (front,
// back), so the SAD consumer drains one set while the other is being filled.
// Candidate order: by 0..ROWS-1, bx 0..BLOCKS_X-1, d 0..min(bx,MAX_DISP).
// Ports:
//   clk_in, rst_in (async, active-low)
//   start_in  : frame start pulse, ignored while busy_out
//   busy_out  : frame in progress
//   done_out  : 1-cycle pulse once the last candidate has been released
//   bus       : ub_* fill handshake and sad_* presentation (master side)
module stereo_block_scheduler #(
  parameter int BLOCKS_X = 40,
  parameter int ROWS     = 320,
  parameter int MAX_DISP = 7,
  parameter int XW       = 9,
  parameter int YW       = 10,
  parameter int DW       = 4
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic start_in,
  output logic busy_out,
  output logic done_out,
  stereo_block_scheduler_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_FILL, DRAIN} state_t;

  // Set index 1 is the front set, 0 the back set.
  localparam logic          FRONT    = 1'b1;
  localparam logic [XW-1:0] BX_LAST  = XW'(BLOCKS_X - 1);
  localparam logic [YW-1:0] ROW_LAST = YW'(ROWS - 1);
  localparam logic [XW-1:0] MAXD_X   = XW'(MAX_DISP);

  state_t              state_q, state_d;
  logic [1:0]          full_q, full_d;
  logic                fill_sel_q, fill_sel_d;
  logic                cons_sel_q, cons_sel_d;
  logic [XW-1:0]       bx_q, bx_d;
  logic [YW-1:0]       by_q, by_d;
  logic [DW-1:0]       d_q, d_d;
  logic                ub_vld_q;
  logic                done_q, done_d;

  // Per-set metadata, captured when the fill for that set is requested.
  logic [1:0][XW-1:0]  mbx_q;
  logic [1:0][YW-1:0]  mby_q;
  logic [1:0][DW-1:0]  md_q;
  logic [1:0]          mlast_q;

  logic [XW-1:0]       dmax;
  logic                is_last_d;
  logic                is_final;
  logic                issue;
  logic                fill_done;
  logic                release_set;
  logic                drain_go;
  logic                drv_ub;

  // Disparity range shrinks near the left edge so bx-d never goes negative.
  assign dmax      = (bx_q < MAXD_X) ? bx_q : MAXD_X;
  assign is_last_d = (XW'(d_q) == dmax);
  assign is_final  = is_last_d && (bx_q == BX_LAST) && (by_q == ROW_LAST);

  assign issue       = (state_q == ISSUE) && !full_q[fill_sel_q];
  assign fill_done   = (state_q == WAIT_FILL) && bus.ub_valid_in;
  assign release_set = full_q[cons_sel_q] && bus.sad_done_in;
  assign drain_go    = (state_q == DRAIN) && (full_q == 2'b00);

  // FSM next state
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE:      if (start_in) state_d = ISSUE;
      ISSUE:     if (issue) state_d = WAIT_FILL;
      WAIT_FILL: if (bus.ub_valid_in) state_d = is_final ? DRAIN : ISSUE;
      DRAIN: begin
        if (drain_go) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default:   state_d = IDLE;
    endcase
  end

  // Candidate counter: only moves when the outstanding fill completes, which
  // keeps the ub_* coordinates stable for the whole request.
  always_comb begin
    bx_d = bx_q;
    by_d = by_q;
    d_d  = d_q;
    if (fill_done) begin
      if (!is_last_d) begin
        d_d = d_q + DW'(1);
      end else begin
        d_d = '0;
        if (bx_q == BX_LAST) begin
          bx_d = '0;
          by_d = (by_q == ROW_LAST) ? '0 : by_q + YW'(1);
        end else begin
          bx_d = bx_q + XW'(1);
        end
      end
    end
    if (drain_go) begin
      bx_d = '0;
      by_d = '0;
      d_d  = '0;
    end
  end

  // Set occupancy. A fill and a release always hit opposite sets (a set being
  // filled is empty, a set being released is full), so both apply together.
  always_comb begin
    full_d = full_q;
    if (fill_done)   full_d[fill_sel_q] = 1'b1;
    if (release_set) full_d[cons_sel_q] = 1'b0;
    fill_sel_d = fill_sel_q ^ fill_done;
    cons_sel_d = cons_sel_q ^ release_set;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      full_q     <= '0;
      fill_sel_q <= FRONT;
      cons_sel_q <= FRONT;
      bx_q       <= '0;
      by_q       <= '0;
      d_q        <= '0;
      ub_vld_q   <= 1'b0;
      done_q     <= 1'b0;
      mbx_q      <= '0;
      mby_q      <= '0;
      md_q       <= '0;
      mlast_q    <= '0;
    end else begin
      state_q    <= state_d;
      full_q     <= full_d;
      fill_sel_q <= fill_sel_d;
      cons_sel_q <= cons_sel_d;
      bx_q       <= bx_d;
      by_q       <= by_d;
      d_q        <= d_d;
      ub_vld_q   <= issue;
      done_q     <= done_d;
      if (issue) begin
        mbx_q[fill_sel_q]   <= bx_q;
        mby_q[fill_sel_q]   <= by_q;
        md_q[fill_sel_q]    <= d_q;
        mlast_q[fill_sel_q] <= is_last_d;
      end
    end
  end

  // Coordinates are only meaningful while a candidate is pending; they read 0
  // in IDLE/DRAIN so the bus is quiet between frames.
  assign drv_ub = (state_q == ISSUE) || (state_q == WAIT_FILL);

  assign bus.ub_valid_out          = ub_vld_q;
  assign bus.ub_left_x_out         = drv_ub ? bx_q : '0;
  assign bus.ub_left_y_out         = drv_ub ? by_q : '0;
  assign bus.ub_right_x_out        = drv_ub ? (bx_q - XW'(d_q)) : '0;
  assign bus.ub_right_y_out        = drv_ub ? by_q : '0;
  assign bus.ub_write_to_front_out = drv_ub && (fill_sel_q == FRONT);

  assign bus.sad_valid_out = full_q[cons_sel_q];
  assign bus.sad_front_out = full_q[cons_sel_q] && (cons_sel_q == FRONT);
  assign bus.sad_bx_out    = full_q[cons_sel_q] ? mbx_q[cons_sel_q] : '0;
  assign bus.sad_by_out    = full_q[cons_sel_q] ? mby_q[cons_sel_q] : '0;
  assign bus.sad_disp_out  = full_q[cons_sel_q] ? md_q[cons_sel_q]  : '0;
  assign bus.sad_last_out  = full_q[cons_sel_q] && mlast_q[cons_sel_q];

  assign busy_out = (state_q != IDLE);
  assign done_out = done_q;

endmodule

// File: tb/tb_stereo_block_scheduler.sv
module tb_stereo_block_scheduler;
  localparam int BX = 3, RW = 2, MD = 1, XW = 9, YW = 10, DW = 4;

  logic clk_in = 1'b0, rst_in = 1'b0, start_in = 1'b0;
  logic busy_out, done_out;

  stereo_block_scheduler_if #(.XW(XW), .YW(YW), .DW(DW)) bus();

  stereo_block_scheduler #(.BLOCKS_X(BX), .ROWS(RW), .MAX_DISP(MD),
                           .XW(XW), .YW(YW), .DW(DW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .busy_out(busy_out), .done_out(done_out), .bus(bus.master));

  always #5 clk_in = ~clk_in;

  typedef struct {int bx; int by; int d; bit last;} cand_t;
  typedef struct {int lx; int ly; int rx; int wtf; int cyc;} pulse_t;

  cand_t  cands[$];
  int     total;
  int     vecs = 0, errs = 0;
  bit     chk_en = 1'b0;

  // reference model state
  bit     m_run = 0, m_out = 0, m_vld = 0, m_done = 0;
  int     m_iss = 0, m_fil = 0;
  bit     fill_par = 0;          // 0: next fill goes to the front set
  cand_t  fifo[$];
  bit     ftag[$];

  // stimulus controls / monitors
  int     fill_mode = 1, sad_mode = 1;
  bit     rnd_start = 1, start_req = 0, rel_req = 0;
  int     cyc = 0, start_cyc = 0, rel_cyc = 0, ndone = 0, nfill = 0;
  pulse_t pq[$];
  cand_t  cq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a frame is a list of candidates; filled sets form a
  // FIFO of depth 2 consumed in fill order. Decisions use pre-edge state.
  initial forever begin
    @(posedge clk_in or negedge rst_in);
    if (!rst_in) begin
      m_run = 0; m_out = 0; m_vld = 0; m_done = 0;
      m_iss = 0; m_fil = 0; fill_par = 0;
      fifo.delete(); ftag.delete();
    end else begin
      bit pr, po; int ps, pi, pf;
      pr = m_run; po = m_out; ps = fifo.size(); pi = m_iss; pf = m_fil;
      m_vld  = pr && !po && (pi < total) && (ps < 2);
      m_done = pr && !po && (pf == total) && (ps == 0);
      if (m_vld) begin m_out = 1; m_iss++; end
      if (po && bus.ub_valid_in) begin
        fifo.push_back(cands[pf]); ftag.push_back(fill_par == 0);
        fill_par = ~fill_par; m_fil++; m_out = 0;
      end
      if (ps > 0 && bus.sad_done_in) begin
        void'(fifo.pop_front()); void'(ftag.pop_front());
      end
      if (m_done) m_run = 0;
      if (!pr && start_in) begin m_run = 1; m_iss = 0; m_fil = 0; end
    end
  end

  // Compare, monitor, then drive the next inputs, all on the falling edge.
  initial begin
    int fcnt;
    bit sd;
    fcnt = 0;
    bus.ub_valid_in = 0; bus.sad_done_in = 0;
    forever begin
      @(negedge clk_in);
      cyc++;
      if (chk_en) begin
        cand_t c; bit drv;
        drv = m_run && (m_fil < total);
        c = '{0, 0, 0, 0};
        if (drv) c = cands[m_fil];
        chk("ub_valid", bus.ub_valid_out, m_vld);
        chk("busy", busy_out, m_run);
        chk("done", done_out, m_done);
        chk("ub_lx", bus.ub_left_x_out, c.bx);
        chk("ub_ly", bus.ub_left_y_out, c.by);
        chk("ub_rx", bus.ub_right_x_out, c.bx - c.d);
        chk("ub_ry", bus.ub_right_y_out, c.by);
        chk("ub_wtf", bus.ub_write_to_front_out, drv && (fill_par == 0));
        c = '{0, 0, 0, 0};
        if (fifo.size() > 0) c = fifo[0];
        chk("sad_valid", bus.sad_valid_out, fifo.size() > 0);
        chk("sad_front", bus.sad_front_out, (fifo.size() > 0) ? ftag[0] : 1'b0);
        chk("sad_bx", bus.sad_bx_out, c.bx);
        chk("sad_by", bus.sad_by_out, c.by);
        chk("sad_disp", bus.sad_disp_out, c.d);
        chk("sad_last", bus.sad_last_out, c.last);
      end
      if (bus.ub_valid_out)
        pq.push_back('{bus.ub_left_x_out, bus.ub_left_y_out, bus.ub_right_x_out,
                       bus.ub_write_to_front_out, cyc});
      if (done_out) ndone++;
      // inputs
      start_in = start_req || (rnd_start && $urandom_range(0, 19) == 0);
      if (start_req) begin start_cyc = cyc; start_req = 0; end
      case (fill_mode)
        0: begin
          bus.ub_valid_in = 0;
          if (bus.ub_valid_out) fcnt = 3;
          else if (fcnt > 0) begin fcnt--; if (fcnt == 0) bus.ub_valid_in = 1; end
        end
        1: bus.ub_valid_in = ($urandom_range(0, 2) == 0);
        default: bus.ub_valid_in = 0;
      endcase
      if (bus.ub_valid_in) nfill++;
      case (sad_mode)
        0: sd = 1;
        1: sd = $urandom_range(0, 1);
        default: sd = rel_req;
      endcase
      if (rel_req) begin rel_cyc = cyc; rel_req = 0; end
      if (bus.sad_valid_out && sd)
        cq.push_back('{bus.sad_bx_out, bus.sad_by_out, bus.sad_disp_out, bus.sad_last_out});
      bus.sad_done_in = sd;
    end
  end

  task automatic wait_done(input int lim);
    int k = 0;
    while (ndone == 0 && k < lim) begin @(negedge clk_in); k++; end
    chk("done_seen", ndone != 0, 1);
    repeat (3) @(negedge clk_in);
  endtask

  task automatic wait_idle(input int lim);
    int k = 0;
    while (busy_out && k < lim) begin @(negedge clk_in); k++; end
    chk("idle_timeout", busy_out, 0);
    repeat (2) @(negedge clk_in);
  endtask

  task automatic clear_mon();
    pq.delete(); cq.delete(); ndone = 0; nfill = 0;
  endtask

  initial begin
    int exp_lx[10] = '{0, 1, 1, 2, 2, 0, 1, 1, 2, 2};
    int exp_rx[10] = '{0, 1, 0, 2, 1, 0, 1, 0, 2, 1};
    int exp_lst[10] = '{1, 0, 1, 0, 1, 1, 0, 1, 0, 1};
    int k;
    for (int y = 0; y < RW; y++)
      for (int x = 0; x < BX; x++)
        for (int d = 0; d <= ((x < MD) ? x : MD); d++)
          cands.push_back('{x, y, d, d == ((x < MD) ? x : MD)});
    total = cands.size();
    chk("model_total", total, 10);
    chk_en = 1;

    // reset held with random inputs
    repeat (6) @(negedge clk_in);
    chk("rst_busy", busy_out, 0);
    chk("rst_sad_valid", bus.sad_valid_out, 0);
    rst_in = 1; rnd_start = 0;
    repeat (8) @(negedge clk_in);
    chk("idle_no_issue", pq.size(), 0);

    // small frame, 4-cycle fills, consumer always ready
    clear_mon(); fill_mode = 0; sad_mode = 0; start_req = 1;
    wait_done(400);
    chk("sf_pulses", pq.size(), 10);
    chk("sf_cons", cq.size(), 10);
    for (int i = 0; i < 10 && i < pq.size(); i++) begin
      chk("sf_lx", pq[i].lx, exp_lx[i]);
      chk("sf_rx", pq[i].rx, exp_rx[i]);
      chk("sf_wtf", pq[i].wtf, (i % 2 == 0) ? 1 : 0);
    end
    for (int i = 0; i < 10 && i < cq.size(); i++) chk("sf_last", cq[i].last, exp_lst[i]);
    if (pq.size() > 0) chk("start_latency", pq[0].cyc - start_cyc, 2);
    chk("sf_ndone", ndone, 1);

    // stalled consumer: front then back fill, then ISSUE waits
    wait_idle(100); clear_mon(); fill_mode = 0; sad_mode = 2; start_req = 1;
    repeat (40) @(negedge clk_in);
    chk("stall_pulses", pq.size(), 2);
    if (pq.size() >= 2) begin
      chk("stall_wtf0", pq[0].wtf, 1);
      chk("stall_wtf1", pq[1].wtf, 0);
    end
    rel_req = 1;
    k = 0;
    while (pq.size() < 3 && k < 20) begin @(negedge clk_in); k++; end
    chk("rel_pulse", pq.size() >= 3, 1);
    if (pq.size() >= 3) begin
      chk("rel_wtf", pq[2].wtf, 1);
      chk("rel_latency", pq[2].cyc - rel_cyc, 2);
    end
    fill_mode = 1; sad_mode = 1;
    wait_done(2000);

    // randomized frames with spurious starts / fills / releases
    for (int f = 0; f < 4; f++) begin
      wait_idle(3000); clear_mon();
      rnd_start = 1; fill_mode = 1; sad_mode = 1; start_req = 1;
      wait_done(3000);
      rnd_start = 0;
    end

    // mid-frame reset after 3 fills
    wait_idle(3000); clear_mon(); fill_mode = 0; sad_mode = 0; start_req = 1;
    k = 0;
    while (nfill < 3 && k < 200) begin @(negedge clk_in); k++; end
    chk("mid_fills", nfill >= 3, 1);
    @(posedge clk_in); #2 rst_in = 0; #1;
    chk("mrst_busy", busy_out, 0);
    chk("mrst_ubv", bus.ub_valid_out, 0);
    chk("mrst_wtf", bus.ub_write_to_front_out, 0);
    chk("mrst_sadv", bus.sad_valid_out, 0);
    chk("mrst_front", bus.sad_front_out, 0);
    chk("mrst_lx", bus.ub_left_x_out, 0);
    @(negedge clk_in); rst_in = 1;
    @(negedge clk_in); clear_mon(); start_req = 1;
    k = 0;
    while (pq.size() < 1 && k < 20) begin @(negedge clk_in); k++; end
    chk("restart_pulse", pq.size() >= 1, 1);
    if (pq.size() >= 1) begin
      chk("restart_lx", pq[0].lx, 0);
      chk("restart_ly", pq[0].ly, 0);
      chk("restart_rx", pq[0].rx, 0);
      chk("restart_wtf", pq[0].wtf, 1);
    end
    wait_done(500);
    chk("restart_ndone", ndone, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
